// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_arb_pkg;

  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REQ_ADDR_W = 5;
  localparam int unsigned REQ_DATA_W = 64;

  typedef enum logic [0:0] {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [REQ_ADDR_W-1:0] rd;
    logic [REQ_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regarb_fifo.sv
// Synchronous FIFO with registered occupancy count; full/empty derive from the count only.
module regarb_fifo
  import regfile_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WB and a buffered long-latency unit,
// with a pending scoreboard for LU destinations. Optional counters: REGARB_PERF_EN.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = REQ_DATA_W,
  parameter int unsigned ADDR_W     = REQ_ADDR_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_WAIT   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] WriteData
`ifdef REGARB_PERF_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       force_cnt
`endif
);

  localparam int unsigned NREG   = 2 ** ADDR_W;
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned FIFO_W = ADDR_W + DATA_W;

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic              fifo_full, fifo_empty, fifo_push;
  logic [FIFO_W-1:0] fifo_head;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic              wb_grant, head_grant, head_denied;
  wr_req_t           wb_req, head_req, grant_req;
  logic              sb_set, sb_clr;

  // LU result buffer; lu_ready reflects only the registered occupancy.
  regarb_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_lu_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({lu_rd, lu_data}),
    .pop       (head_grant),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign lu_ready    = !fifo_full;
  assign fifo_push   = lu_valid && lu_ready;
  assign head_rd     = fifo_head[FIFO_W-1 -: ADDR_W];
  assign head_data   = fifo_head[DATA_W-1:0];
  assign head_denied = !fifo_empty && !head_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_NORMAL;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next state and head-wait counter.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ARB_NORMAL: begin
        if (head_grant) begin
          wait_d = '0;
        end else if (head_denied) begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q == WAIT_W'(MAX_WAIT - 1)) state_d = ARB_FORCE;
        end
      end
      ARB_FORCE: begin
        wait_d  = '0;
        state_d = ARB_NORMAL;
      end
      default: begin
        wait_d  = '0;
        state_d = ARB_NORMAL;
      end
    endcase
  end

  // Grant decode: WB has priority except in the single forced-drain cycle.
  always_comb begin
    wb_ready   = 1'b1;
    wb_grant   = 1'b0;
    head_grant = 1'b0;
    case (state_q)
      ARB_NORMAL: begin
        wb_grant   = wb_valid;
        head_grant = !wb_valid && !fifo_empty;
      end
      ARB_FORCE: begin
        wb_ready   = 1'b0;
        head_grant = !fifo_empty;
      end
      default: begin
        wb_ready = 1'b0;
      end
    endcase
  end

  always_comb begin
    wb_req.valid   = wb_grant;
    wb_req.rd      = REQ_ADDR_W'(wb_rd);
    wb_req.data    = REQ_DATA_W'(wb_data);
    head_req.valid = head_grant;
    head_req.rd    = REQ_ADDR_W'(head_rd);
    head_req.data  = REQ_DATA_W'(head_data);
    if (wb_grant)        grant_req = wb_req;
    else if (head_grant) grant_req = head_req;
    else                 grant_req = '0;
  end

  // Registered write port; x0 writes are consumed but never enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      RD        <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= grant_req.valid && (grant_req.rd != '0);
      if (grant_req.valid) begin
        RD        <= ADDR_W'(grant_req.rd);
        WriteData <= DATA_W'(grant_req.data);
      end
    end
  end

  assign issue_ready = !pending_q[issue_rd];
  assign sb_set      = issue_valid && issue_ready && (issue_rd != '0);
  assign sb_clr      = head_grant && (head_rd != '0);
  assign rs1_busy    = (RS1 != '0) && pending_q[RS1];
  assign rs2_busy    = (RS2 != '0) && pending_q[RS2];

  // Set is applied after clear so a same-cycle issue keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (sb_clr) pending_d[head_rd]  = 1'b0;
    if (sb_set) pending_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

`ifdef REGARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
      force_cnt    <= '0;
    end else begin
      if (wb_valid && !fifo_empty && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 32'd1;
      if ((state_q == ARB_FORCE) && (force_cnt != '1))
        force_cnt <= force_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_ready;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [63:0] lu_data;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  RS1, RS2;
  logic        rs1_busy, rs2_busy;
  logic        RegWrite;
  logic [4:0]  RD;
  logic [63:0] WriteData;
`ifdef REGARB_PERF_EN
  logic [31:0] conflict_cnt, force_cnt;
`endif

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .lu_valid    (lu_valid),
    .lu_rd       (lu_rd),
    .lu_data     (lu_data),
    .lu_ready    (lu_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .RS1         (RS1),
    .RS2         (RS2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .RegWrite    (RegWrite),
    .RD          (RD),
    .WriteData   (WriteData)
`ifdef REGARB_PERF_EN
    ,
    .conflict_cnt(conflict_cnt),
    .force_cnt   (force_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite got %0b exp 0", RegWrite); end
    checks++; if (RD !== 5'd0) begin errors++; $display("FAIL rst_rd got %0d exp 0", RD); end
    checks++; if (WriteData !== 64'd0) begin errors++; $display("FAIL rst_wdata got %0h exp 0", WriteData); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL rst_lu_ready got %0b exp 1", lu_ready); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_ready got %0b exp 1", issue_ready); end
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL rst_wb_ready got %0b exp 1", wb_ready); end
    checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b%0b exp 00", rs1_busy, rs2_busy); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_wb_only();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h1234;
    @(negedge clk);
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL wb_ready got %0b exp 1", wb_ready); end
    tick();
    wb_valid = 1'b0;
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL wb_regwrite got %0b exp 1", RegWrite); end
    checks++; if (RD !== 5'd7) begin errors++; $display("FAIL wb_rd got %0d exp 7", RD); end
    checks++; if (WriteData !== 64'h1234) begin errors++; $display("FAIL wb_wdata got %0h exp 1234", WriteData); end
    @(negedge clk);
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL wb_ready_idle got %0b exp 1", wb_ready); end
    tick();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL wb_regwrite_idle got %0b exp 0", RegWrite); end
  endtask

  task automatic test_starvation();
    RS1 = 5'd9; issue_valid = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL starve_issue_ready got %0b exp 1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL starve_busy_set got %0b exp 1", rs1_busy); end
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 64'hAA;
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 64'h100;
    tick();
    lu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_data = 64'h200 + 64'(i);
      @(negedge clk);
      checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL starve_deny%0d_wb_ready got %0b exp 1", i, wb_ready); end
      tick();
      checks++; if (RD !== 5'd1 || WriteData !== 64'h200 + 64'(i)) begin errors++; $display("FAIL starve_deny%0d_write got rd=%0d data=%0h exp rd=1 data=%0h", i, RD, WriteData, 64'h200 + 64'(i)); end
    end
    @(negedge clk);
    checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL starve_force_wb_ready got %0b exp 0", wb_ready); end
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL starve_busy_hold got %0b exp 1", rs1_busy); end
    tick();
    checks++; if (RegWrite !== 1'b1 || RD !== 5'd9 || WriteData !== 64'hAA) begin errors++; $display("FAIL starve_force_write got we=%0b rd=%0d data=%0h exp we=1 rd=9 data=aa", RegWrite, RD, WriteData); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL starve_busy_clear got %0b exp 0", rs1_busy); end
    @(negedge clk);
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL starve_after_wb_ready got %0b exp 1", wb_ready); end
    wb_valid = 1'b0;
    tick();
  endtask

  task automatic test_fifo_full();
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 64'h22;
    lu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lu_rd = 5'(10 + i); lu_data = 64'hB0 + 64'(i);
      @(negedge clk);
      checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_push%0d_lu_ready got %0b exp 1", i, lu_ready); end
      tick();
    end
    lu_valid = 1'b0;
    @(negedge clk);
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_pop_lu_ready got %0b exp 0", lu_ready); end
    checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL full_force_wb_ready got %0b exp 0", wb_ready); end
    tick();
    checks++; if (RegWrite !== 1'b1 || RD !== 5'd10 || WriteData !== 64'hB0) begin errors++; $display("FAIL full_head0 got we=%0b rd=%0d data=%0h exp we=1 rd=10 data=b0", RegWrite, RD, WriteData); end
    wb_valid = 1'b0;
    @(negedge clk);
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_after_lu_ready got %0b exp 1", lu_ready); end
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++; if (RD !== 5'(10 + i) || WriteData !== 64'hB0 + 64'(i)) begin errors++; $display("FAIL full_drain%0d got rd=%0d data=%0h exp rd=%0d data=%0h", i, RD, WriteData, 10 + i, 64'hB0 + 64'(i)); end
    end
    tick();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL full_empty_regwrite got %0b exp 0", RegWrite); end
  endtask

  task automatic test_scoreboard();
    RS1 = 5'd3; RS2 = 5'd3; issue_valid = 1'b1; issue_rd = 5'd3;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sb_first_issue_ready got %0b exp 1", issue_ready); end
    tick();
    checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_rs2_busy got %0b exp 1", rs2_busy); end
    @(negedge clk);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sb_waw_stall got %0b exp 0", issue_ready); end
    issue_valid = 1'b0;
    tick();
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 64'h33;
    tick();
    lu_valid = 1'b0;
    tick();
    checks++; if (RD !== 5'd3 || WriteData !== 64'h33) begin errors++; $display("FAIL sb_result1 got rd=%0d data=%0h exp rd=3 data=33", RD, WriteData); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_clear got %0b exp 0", rs1_busy); end
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 64'h34;
    tick();
    lu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd3;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sb_same_issue_ready got %0b exp 1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    checks++; if (RD !== 5'd3 || WriteData !== 64'h34) begin errors++; $display("FAIL sb_result2 got rd=%0d data=%0h exp rd=3 data=34", RD, WriteData); end
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %0b exp 1", rs1_busy); end
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 64'h35;
    tick();
    lu_valid = 1'b0;
    tick();
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_final_clear got %0b exp 0", rs1_busy); end
  endtask

  task automatic test_x0();
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 64'hFF;
    tick();
    lu_valid = 1'b0;
    tick();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL x0_lu_regwrite got %0b exp 0", RegWrite); end
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 64'h44;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL x0_popped%0d_wb_ready got %0b exp 1", i, wb_ready); end
      tick();
    end
    wb_valid = 1'b0;
    wb_rd = 5'd0; wb_data = 64'h55; wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL x0_wb_regwrite got %0b exp 0", RegWrite); end
    RS1 = 5'd0; issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    issue_valid = 1'b0;
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_rs1_busy got %0b exp 0", rs1_busy); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL x0_issue_ready got %0b exp 1", issue_ready); end
  endtask

  task automatic test_reset_mid();
    RS1 = 5'd5; issue_valid = 1'b1; issue_rd = 5'd5;
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 64'h66;
    lu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lu_rd = 5'(20 + i); lu_data = 64'hC0 + 64'(i);
      tick();
      issue_valid = 1'b0;
    end
    lu_valid = 1'b0;
    checks++; if (RegWrite !== 1'b1 || rs1_busy !== 1'b1) begin errors++; $display("FAIL rmid_pre got we=%0b busy=%0b exp we=1 busy=1", RegWrite, rs1_busy); end
    reset = 1'b1;
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rmid_regwrite got %0b exp 0", RegWrite); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL rmid_lu_ready got %0b exp 1", lu_ready); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b exp 0", rs1_busy); end
    wb_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rmid_empty%0d got %0b exp 0", i, RegWrite); end
    end
  endtask

  initial begin
    reset = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    RS1 = '0; RS2 = '0;
    test_reset();
    test_wb_only();
    test_starvation();
    test_fifo_full();
    test_scoreboard();
    test_x0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (RegWrite/RD/WriteData) between two requesters:
  - the pipeline writeback stage (WB);
  - a long-latency execution unit (LU, e.g. mul/div) whose results are buffered in a small FIFO.
- Keeps a per-register pending scoreboard for LU destinations so decode can stall on RAW/WAW hazards.
- Sits between the WB/LU stages and the register file; drives the register file's write inputs directly.

Parameters:
- DATA_W, 64, data width of register values.
- ADDR_W, 5, register index width (32 registers).
- FIFO_DEPTH, 4, LU result buffer entries (power of 2, >=2).
- MAX_WAIT, 3, cycles a non-empty FIFO head may be denied before the forced-drain cycle.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- wb_valid  in  1  WB stage has a write.
- wb_rd  in  ADDR_W  WB destination.
- wb_data  in  DATA_W  WB value.
- wb_ready  out  1  WB write accepted this cycle; WB holds its write while low.
- lu_valid  in  1  LU result available.
- lu_rd  in  ADDR_W  LU destination.
- lu_data  in  DATA_W  LU value.
- lu_ready  out  1  FIFO can accept (count < FIFO_DEPTH).
- issue_valid  in  1  decode issues an LU op.
- issue_rd  in  ADDR_W  its destination.
- issue_ready  out  1  issue allowed.
- RS1, RS2  in  ADDR_W  decode source indices.
- rs1_busy, rs2_busy  out  1  source pending in scoreboard.
- RegWrite  out  1  register-file write enable (registered).
- RD  out  ADDR_W  write index (registered).
- WriteData  out  DATA_W  write data (registered).

Behaviour:
- Reset values:
  - RegWrite=0, RD=0, WriteData=0.
  - FIFO empty, scoreboard all clear, wait_cnt=0, FSM=NORMAL.
  - Consequently lu_ready=1, issue_ready=1, rs*_busy=0, wb_ready=1.
- Reset asserted mid-operation discards buffered results and pending bits.
- FSM states: NORMAL and FORCE.
  - NORMAL:
    - wb_ready=1; WB wins the port when wb_valid.
    - Otherwise the FIFO head is granted if non-empty.
    - wait_cnt increments each cycle the FIFO is non-empty and the head is not granted; it clears on any head grant.
    - On a denied cycle where wait_cnt==MAX_WAIT-1: go to FORCE.
  - FORCE (one cycle):
    - wb_ready=0; the FIFO head is granted; wait_cnt=0; return to NORMAL.
- Grant to write: the granted write appears on RegWrite/RD/WriteData at the next rising edge (1-cycle latency). The register file commits on the following edge.
- FIFO:
  - Push when lu_valid && lu_ready; pop on head grant.
  - lu_ready is derived from the registered count only. When full, it stays 0 even if a pop occurs that cycle.
  - No bypass: a result pushed into an empty FIFO is grantable the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- x0 handling:
  - A WB or LU write with rd==0 is consumed normally (ready, pop) but produces RegWrite=0.
  - An issue with rd==0 sets no pending bit.
- Scoreboard:
  - Set pending[issue_rd] on issue_valid && issue_ready.
  - Clear pending[rd] when a FIFO head with that rd is granted.
  - If set and clear hit the same index in the same cycle, set wins.
  - issue_ready=0 when pending[issue_rd]=1 (WAW stall).
  - rsN_busy = pending[RSN] (combinational; always 0 for index 0).
- A WB write never affects the scoreboard.

Optional Feature:
- Macro REGARB_PERF_EN.
- Defined:
  - Adds output ports conflict_cnt (32b) and force_cnt (32b), both reset to 0, saturating.
  - conflict_cnt increments on each cycle WB and a non-empty FIFO head both request.
  - force_cnt increments on each FORCE cycle.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package regfile_arb_pkg holds:
  - the FSM state enum (ARB_NORMAL, ARB_FORCE);
  - the write-request struct {valid, rd, data};
  - the constant REG_COUNT=32.
- One sub-module, regarb_fifo: parameterised synchronous FIFO with registered count, full/empty, async active-high reset. The arbiter instantiates it for LU results.

Test Plan:
- Reset mid-stream: fill FIFO with 3 entries, pend x5, assert reset -> same cycle RegWrite=0, lu_ready=1, rs busy for x5 =0, FIFO empty after release.
- WB-only: wb_valid rd=7 data=0x1234 -> next edge RegWrite=1, RD=7, WriteData=0x1234; wb_ready=1 throughout.
- Starvation: issue x9, LU returns x9=0xAA, WB valid every cycle, MAX_WAIT=3:
  - 3 denied cycles, then FORCE with wb_ready=0;
  - next edge RD=9, WriteData=0xAA; rs1_busy for RS1=9 drops.
- FIFO full: push 4 LU results with WB saturating -> lu_ready=0 after the 4th push; it stays 0 during the pop cycle and returns to 1 the cycle after.
- Scoreboard WAW/same-cycle: pending x3, issue_rd=3 -> issue_ready=0. Head grant for x3 in the same cycle as a new issue to x3 -> pending[3] remains 1.
- x0: LU result rd=0 data=0xFF -> popped, RegWrite stays 0; issue_rd=0 -> no pending bit, rs1_busy(RS1=0)=0.
